// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM-style pipeline stall/flush controller.
package arm_pipe_pkg;

    // Register-number width and the always-zero register.
    localparam int                REG_AW = 5;
    localparam logic [REG_AW-1:0] XZR    = 5'd31;

    // Controller FSM states.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } stall_state_t;

    // Bundle of the per-cycle pipeline-register control strobes.
    typedef struct packed {
        logic stall_pc;
        logic stall_ifid;
        logic stall_idex;
        logic stall_exmem;
        logic bubble_idex;
        logic flush_ifid;
        logic flush_idex;
    } stall_ctrl_t;

    localparam stall_ctrl_t CTRL_IDLE = '0;

    // Freeze every stallable register (memory wait and fault).
    function automatic stall_ctrl_t ctrl_hold_all();
        stall_ctrl_t c;
        c             = CTRL_IDLE;
        c.stall_pc    = 1'b1;
        c.stall_ifid  = 1'b1;
        c.stall_idex  = 1'b1;
        c.stall_exmem = 1'b1;
        return c;
    endfunction

    // Normal-flow decision: a taken branch squashes the ID instruction,
    // so it wins over a load-use hazard seen in the same cycle.
    function automatic stall_ctrl_t ctrl_run(input logic branch_taken, input logic lu);
        stall_ctrl_t c;
        c = CTRL_IDLE;
        if (branch_taken) begin
            c.flush_ifid = 1'b1;
            c.flush_idex = 1'b1;
        end else if (lu) begin
            c.stall_pc    = 1'b1;
            c.stall_ifid  = 1'b1;
            c.bubble_idex = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard inputs and stall/flush outputs exchanged between the pipeline
// datapath (master) and the stall controller (slave).
interface pipe_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    import arm_pipe_pkg::*;

    logic [REG_AW-1:0] id_rn;
    logic [REG_AW-1:0] id_rm;
    logic              id_uses_rn;
    logic              id_uses_rm;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_rd;
    logic              dmem_busy;
    logic              branch_taken;

    logic              Stall_PC;
    logic              Stall_IFID;
    logic              Stall_IDEX;
    logic              Stall_EXMEM;
    logic              Bubble_IDEX;
    logic              Flush_IFID;
    logic              Flush_IDEX;
    logic              mem_fault;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output id_rn, id_rm, id_uses_rn, id_uses_rm,
        output ex_mem_read, ex_rd, dmem_busy, branch_taken,
        input  Stall_PC, Stall_IFID, Stall_IDEX, Stall_EXMEM,
        input  Bubble_IDEX, Flush_IFID, Flush_IDEX,
        input  mem_fault, stall_cycles
    );

    modport slave (
        input  id_rn, id_rm, id_uses_rn, id_uses_rm,
        input  ex_mem_read, ex_rd, dmem_busy, branch_taken,
        output Stall_PC, Stall_IFID, Stall_IDEX, Stall_EXMEM,
        output Bubble_IDEX, Flush_IFID, Flush_IDEX,
        output mem_fault, stall_cycles
    );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator: the load in EX writes a register
// that the instruction in ID actually reads. XZR never carries a dependency.
module load_use_detect
    import arm_pipe_pkg::*;
(
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    input  logic              id_uses_rn,
    input  logic              id_uses_rm,
    output logic              lu
);

    logic rn_hit;
    logic rm_hit;

    assign rn_hit = id_uses_rn && (id_rn == ex_rd);
    assign rm_hit = id_uses_rm && (id_rm == ex_rd);
    assign lu     = ex_mem_read && (ex_rd != XZR) && (rn_hit || rm_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, whole-pipe hold during
// data-memory waits, wrong-path flush on taken branches, a memory-wait
// timeout trap and a saturating stall-cycle counter.
module pipe_stall_ctrl
    import arm_pipe_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input logic               clk,
    input logic               Reset,
    pipe_stall_ctrl_if.slave  bus
);

    // The wait counter records busy cycles spent in MEM_WAIT; the entry
    // cycle (in RUN) is busy cycle 1, so MEM_WAIT cycle k is busy cycle k+2.
    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 2) ? TIMEOUT - 2 : 0);

    stall_state_t      state;
    stall_state_t      next_state;
    stall_ctrl_t       ctrl;
    logic              lu;
    logic              wait_clr;
    logic              wait_inc;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  stall_cnt;

    load_use_detect u_lu (
        .ex_mem_read (bus.ex_mem_read),
        .ex_rd       (bus.ex_rd),
        .id_rn       (bus.id_rn),
        .id_rm       (bus.id_rm),
        .id_uses_rn  (bus.id_uses_rn),
        .id_uses_rm  (bus.id_uses_rm),
        .lu          (lu)
    );

    // Next-state and same-cycle control outputs from state and hazard inputs.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        next_state = state;
        ctrl       = CTRL_IDLE;
        wait_clr   = 1'b0;
        wait_inc   = 1'b0;
        unique case (state)
            RUN: begin
                if (bus.dmem_busy) begin
                    ctrl       = ctrl_hold_all();
                    wait_clr   = 1'b1;
                    next_state = (TIMEOUT <= 1) ? FAULT : MEM_WAIT;
                end else begin
                    ctrl = ctrl_run(bus.branch_taken, lu);
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_busy) begin
                    ctrl = ctrl_hold_all();
                    if (wait_cnt == WAIT_LAST) begin
                        next_state = FAULT;
                    end else begin
                        wait_inc = 1'b1;
                    end
                end else begin
                    // Release cycle behaves like RUN so a pending branch or
                    // load-use is not lost.
                    ctrl       = ctrl_run(bus.branch_taken, lu);
                    next_state = RUN;
                end
            end
            FAULT: begin
                ctrl = ctrl_hold_all();
            end
            default: begin
                next_state = RUN;
            end
        endcase
        // While reset is asserted the pipeline registers must be free to load
        // their reset values.
        if (!Reset) begin
            ctrl = CTRL_IDLE;
        end
    end

    // FSM state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples the same pre-edge values.
        if (!Reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Consecutive memory-wait cycle counter, cleared on MEM_WAIT entry.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            wait_cnt <= '0;
        end else if (wait_clr) begin
            wait_cnt <= '0;
        end else if (wait_inc) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            stall_cnt <= '0;
        end else if (ctrl.stall_pc && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.Stall_PC     = ctrl.stall_pc;
    assign bus.Stall_IFID   = ctrl.stall_ifid;
    assign bus.Stall_IDEX   = ctrl.stall_idex;
    assign bus.Stall_EXMEM  = ctrl.stall_exmem;
    assign bus.Bubble_IDEX  = ctrl.bubble_idex;
    assign bus.Flush_IFID   = ctrl.flush_ifid;
    assign bus.Flush_IDEX   = ctrl.flush_idex;
    assign bus.mem_fault    = Reset && (state == FAULT);
    assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: two instances (short timeout with a
// narrow counter, and defaults) share directed and random stimulus and are
// compared each cycle against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;
    import arm_pipe_pkg::*;

    localparam int TO0 = 8;
    localparam int CW0 = 4;
    localparam int TO1 = 255;
    localparam int CW1 = 32;

    logic clk;
    logic Reset;

    pipe_stall_ctrl_if #(.CNT_W(CW0)) bus0 ();
    pipe_stall_ctrl_if #(.CNT_W(CW1)) bus1 ();

    pipe_stall_ctrl #(.TIMEOUT(TO0), .CNT_W(CW0)) dut0 (.clk(clk), .Reset(Reset), .bus(bus0.slave));
    pipe_stall_ctrl #(.TIMEOUT(TO1), .CNT_W(CW1)) dut1 (.clk(clk), .Reset(Reset), .bus(bus1.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observed outputs: {Stall_PC, Stall_IFID, Stall_IDEX, Stall_EXMEM,
    // Bubble_IDEX, Flush_IFID, Flush_IDEX, mem_fault}
    logic [7:0]  obs_ctrl [2];
    logic [63:0] obs_cnt  [2];
    assign obs_ctrl[0] = {bus0.Stall_PC, bus0.Stall_IFID, bus0.Stall_IDEX, bus0.Stall_EXMEM,
                          bus0.Bubble_IDEX, bus0.Flush_IFID, bus0.Flush_IDEX, bus0.mem_fault};
    assign obs_ctrl[1] = {bus1.Stall_PC, bus1.Stall_IFID, bus1.Stall_IDEX, bus1.Stall_EXMEM,
                          bus1.Bubble_IDEX, bus1.Flush_IFID, bus1.Flush_IDEX, bus1.mem_fault};
    assign obs_cnt[0]  = 64'(bus0.stall_cycles);
    assign obs_cnt[1]  = 64'(bus1.stall_cycles);

    // Stimulus values
    logic [4:0] s_rn, s_rm, s_rd;
    logic       s_urn, s_urm, s_mr, s_busy, s_br;

    // Reference model state per instance
    int              m_run   [2];
    bit              m_fault [2];
    longint unsigned m_cnt   [2];
    int              to_p    [2] = '{TO0, TO1};
    longint unsigned cmax    [2] = '{64'd15, 64'hFFFF_FFFF};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply();
        bus0.id_rn = s_rn;  bus0.id_rm = s_rm;  bus0.id_uses_rn = s_urn; bus0.id_uses_rm = s_urm;
        bus0.ex_mem_read = s_mr; bus0.ex_rd = s_rd; bus0.dmem_busy = s_busy; bus0.branch_taken = s_br;
        bus1.id_rn = s_rn;  bus1.id_rm = s_rm;  bus1.id_uses_rn = s_urn; bus1.id_uses_rm = s_urm;
        bus1.ex_mem_read = s_mr; bus1.ex_rd = s_rd; bus1.dmem_busy = s_busy; bus1.branch_taken = s_br;
    endtask

    // Expected outputs for the current cycle, straight from the rules.
    function automatic logic [7:0] model_out(input int d);
        logic lu;
        lu = s_mr && (s_rd != 5'd31) && ((s_urn && s_rn == s_rd) || (s_urm && s_rm == s_rd));
        if (!Reset)     return 8'b0000_0000;
        if (m_fault[d]) return 8'b1111_0001;
        if (s_busy)     return 8'b1111_0000;
        if (s_br)       return 8'b0000_0110;
        if (lu)         return 8'b1100_1000;
        return 8'b0000_0000;
    endfunction

    task automatic model_advance(input int d, input logic [7:0] o);
        if (!Reset) begin
            m_run[d]   = 0;
            m_fault[d] = 1'b0;
            m_cnt[d]   = 0;
            return;
        end
        if (o[7] && m_cnt[d] < cmax[d]) m_cnt[d]++;
        if (!m_fault[d]) begin
            if (s_busy) begin
                m_run[d]++;
                if (m_run[d] >= to_p[d]) m_fault[d] = 1'b1;
            end else begin
                m_run[d] = 0;
            end
        end
    endtask

    // One clock: drive, compare at the falling edge, advance model at the rising edge.
    task automatic step(input string tag);
        logic [7:0] e [2];
        apply();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            e[d] = model_out(d);
            check($sformatf("%s.ctrl%0d", tag, d), 64'(obs_ctrl[d]), 64'(e[d]));
            check($sformatf("%s.cnt%0d", tag, d), obs_cnt[d], m_cnt[d]);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_advance(d, e[d]);
        #1;
    endtask

    task automatic clear_stim();
        s_rn = 5'd0; s_rm = 5'd0; s_rd = 5'd0;
        s_urn = 1'b0; s_urm = 1'b0; s_mr = 1'b0; s_busy = 1'b0; s_br = 1'b0;
    endtask

    task automatic set_lu();
        s_mr = 1'b1; s_rd = 5'd3; s_rn = 5'd3; s_urn = 1'b1;
    endtask

    function automatic logic [4:0] pick_reg();
        int v;
        v = $urandom_range(0, 4);
        return (v == 4) ? 5'd31 : 5'(v);
    endfunction

    initial begin
        int busy_left;
        clear_stim();
        Reset = 1'b0;
        apply();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            m_run[d] = 0; m_fault[d] = 1'b0; m_cnt[d] = 0;
        end
        step("reset");
        Reset = 1'b1;

        // Load-use: one bubble, counter 0 -> 1
        set_lu();
        step("lu");
        clear_stim();
        step("lu_after");
        check("lu_cnt", obs_cnt[0], 64'd1);

        // X31 never hazards
        s_mr = 1'b1; s_rd = 5'd31; s_rn = 5'd31; s_urn = 1'b1;
        step("xzr");
        check("xzr_ctrl", 64'(obs_ctrl[0]), 64'd0);

        // Branch beats load-use
        clear_stim(); set_lu(); s_br = 1'b1;
        step("br_lu");
        clear_stim();

        // Memory wait of 4 cycles
        Reset = 1'b0; step("rst1"); Reset = 1'b1;
        s_busy = 1'b1;
        repeat (4) step("busy");
        s_busy = 1'b0;
        step("release");
        check("wait_cnt0", obs_cnt[0], 64'd4);
        check("wait_cnt1", obs_cnt[1], 64'd4);

        // One-cycle pulse with a pending load-use honoured on release
        s_busy = 1'b1; step("pulse");
        s_busy = 1'b0; set_lu(); step("pulse_rel_lu");
        clear_stim();

        // Timeout on instance 0 only
        s_busy = 1'b1;
        repeat (10) step("timeout");
        check("fault0", 64'(bus0.mem_fault), 64'd1);
        check("fault1", 64'(bus1.mem_fault), 64'd0);
        s_busy = 1'b0;
        repeat (3) step("fault_hold");
        check("fault_sticky", 64'(bus0.mem_fault), 64'd1);

        // Reset out of FAULT
        Reset = 1'b0;
        step("rst_fault");
        Reset = 1'b1;
        step("post_rst");
        check("post_rst_fault", 64'(bus0.mem_fault), 64'd0);
        check("post_rst_cnt", obs_cnt[0], 64'd0);

        // Saturation of the 4-bit counter
        set_lu();
        repeat (20) step("sat");
        check("sat_cnt0", obs_cnt[0], 64'd15);
        check("sat_cnt1", obs_cnt[1], 64'd20);
        clear_stim();

        // Randomised traffic
        busy_left = 0;
        for (int i = 0; i < 600; i++) begin
            s_rn  = pick_reg();
            s_rm  = pick_reg();
            s_rd  = pick_reg();
            s_urn = 1'($urandom_range(0, 1));
            s_urm = 1'($urandom_range(0, 1));
            s_mr  = 1'($urandom_range(0, 1));
            s_br  = ($urandom_range(0, 5) == 0);
            if (busy_left > 0) begin
                s_busy = 1'b1;
                busy_left--;
            end else if ($urandom_range(0, 7) == 0) begin
                s_busy = 1'b1;
                busy_left = $urandom_range(0, 11);
            end else begin
                s_busy = 1'b0;
            end
            Reset = ($urandom_range(0, 59) != 0);
            step("rand");
        end
        Reset = 1'b1;
        clear_stim();
        step("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
